// File: rtl/led_pkg.sv
// led_pkg: shared types, default parameters and helpers for the LED fade PWM stage.
package led_pkg;

  // Per-channel fade state.
  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RISING  = 2'd1,
    ON      = 2'd2,
    FALLING = 2'd3
  } led_state_t;

  // Duty / PWM counter width.
  localparam int PWM_BITS_DEFAULT = 8;

  // Clock cycles per one-LSB duty step (about 1 s full fade at 20 MHz).
  localparam int RAMP_DIV_DEFAULT = 78_125;

  // Largest duty value for a given width; also the PWM period in clocks.
  function automatic int maxd(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: sequencer-side level inputs and LED-pin side PWM outputs.
// master = sequencer / board side, slave = the fade PWM stage.
interface led_fade_pwm_if;

  logic led_red_in;
  logic led_green_in;
  logic led_blue_in;
  logic pwm_red;
  logic pwm_green;
  logic pwm_blue;
  logic fading;

  modport master (
    output led_red_in,
    output led_green_in,
    output led_blue_in,
    input  pwm_red,
    input  pwm_green,
    input  pwm_blue,
    input  fading
  );

  modport slave (
    input  led_red_in,
    input  led_green_in,
    input  led_blue_in,
    output pwm_red,
    output pwm_green,
    output pwm_blue,
    output fading
  );

endinterface

// File: rtl/led_fade_channel.sv
// led_fade_channel: one colour channel -- fade FSM, duty register, optional
// gamma mapping, period-aligned shadow register and PWM comparator.
// Optional build macro: LED_FADE_GAMMA_EN (square-law duty mapping).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   OFF     | duty = 0, output dark, waiting for target = 1
//   RISING  | duty stepping up by one per ramp tick
//   ON      | duty = MAXD, output fully lit
//   FALLING | duty stepping down by one per ramp tick
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                target,
  input  logic                ramp_tick,
  input  logic                pwm_wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm,
  output logic                fading_nx
);

  localparam logic [PWM_BITS-1:0] MAXD = PWM_BITS'(maxd(PWM_BITS));
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  led_state_t          state_q;
  led_state_t          state_nx;
  led_state_t          st_up;
  led_state_t          st_dn;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_nx;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  logic [PWM_BITS-1:0] duty_eff;
  logic [PWM_BITS-1:0] shadow_q;
  logic                pwm_q;

  // Saturating one-step neighbours of the current duty and the state each lands in.
  always_comb begin
    duty_up = (duty_q == MAXD) ? MAXD : duty_q + ONE;
    duty_dn = (duty_q == '0)   ? '0   : duty_q - ONE;
    st_up   = (duty_up == MAXD) ? ON  : RISING;
    st_dn   = (duty_dn == '0)   ? OFF : FALLING;
  end

  // Next-state and next-duty; only a ramp tick moves the channel, and a
  // reversal mid-ramp steps from the current duty instead of jumping.
  always_comb begin
    state_nx = state_q;
    duty_nx  = duty_q;
    if (ramp_tick) begin
      case (state_q)
        OFF: begin
          if (target) begin
            state_nx = st_up;
            duty_nx  = duty_up;
          end
        end
        RISING, FALLING: begin
          if (target) begin
            state_nx = st_up;
            duty_nx  = duty_up;
          end else begin
            state_nx = st_dn;
            duty_nx  = duty_dn;
          end
        end
        ON: begin
          if (!target) begin
            state_nx = st_dn;
            duty_nx  = duty_dn;
          end
        end
        default: begin
          state_nx = OFF;
          duty_nx  = '0;
        end
      endcase
    end
  end

  // FSM state and duty register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      duty_q  <= '0;
    end else begin
      state_q <= state_nx;
      duty_q  <= duty_nx;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;

  // Square-law mapping for a perceptually linear fade; full scale stays full scale.
  always_comb begin
    duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
    duty_eff = (duty_q == MAXD) ? MAXD : duty_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign duty_eff = duty_q;
`endif

  // Shadow duty loads only at the period wrap so a pulse in flight is never cut
  // or stretched; the comparator drives the registered pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (pwm_wrap) begin
        shadow_q <= duty_eff;
      end
      pwm_q <= (pwm_cnt < shadow_q);
    end
  end

  assign pwm       = pwm_q;
  assign fading_nx = (state_nx == RISING) || (state_nx == FALLING);

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: turns the sequencer's on/off RGB levels into linear PWM fades.
// Holds the input registers, the shared ramp prescaler, the shared PWM period
// counter and the fading flag; each colour is a led_fade_channel.
// Optional build macro: LED_FADE_GAMMA_EN (handled inside led_fade_channel).
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  parameter int RAMP_DIV = RAMP_DIV_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  led_fade_pwm_if.slave  bus
);

  localparam int                  MAXD_I   = maxd(PWM_BITS);
  localparam int                  PS_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAXD_I - 1);

  logic [2:0]          target_q;
  logic [PS_W-1:0]     ps_q;
  logic                ramp_tick;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_wrap;
  logic [2:0]          pwm_ch;
  logic [2:0]          fade_nx;
  logic                fading_q;

  // Register the sequencer levels once; bit 0 red, 1 green, 2 blue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
    end else begin
      target_q <= {bus.led_blue_in, bus.led_green_in, bus.led_red_in};
    end
  end

  // Shared ramp prescaler, 0..RAMP_DIV-1; the tick is the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else if (ps_q == PS_LAST) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  assign ramp_tick = (ps_q == PS_LAST);

  // Shared PWM period counter, 0..MAXD-1, so a period is MAXD clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else if (pwm_cnt_q == CNT_LAST) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  assign pwm_wrap = (pwm_cnt_q == CNT_LAST);

  led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_red (
    .clk       (clk),
    .rst       (rst),
    .target    (target_q[0]),
    .ramp_tick (ramp_tick),
    .pwm_wrap  (pwm_wrap),
    .pwm_cnt   (pwm_cnt_q),
    .pwm       (pwm_ch[0]),
    .fading_nx (fade_nx[0])
  );

  led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_green (
    .clk       (clk),
    .rst       (rst),
    .target    (target_q[1]),
    .ramp_tick (ramp_tick),
    .pwm_wrap  (pwm_wrap),
    .pwm_cnt   (pwm_cnt_q),
    .pwm       (pwm_ch[1]),
    .fading_nx (fade_nx[1])
  );

  led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch_blue (
    .clk       (clk),
    .rst       (rst),
    .target    (target_q[2]),
    .ramp_tick (ramp_tick),
    .pwm_wrap  (pwm_wrap),
    .pwm_cnt   (pwm_cnt_q),
    .pwm       (pwm_ch[2]),
    .fading_nx (fade_nx[2])
  );

  // fading follows the channels' next states so it lines up with the duty registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fading_q <= 1'b0;
    end else begin
      fading_q <= |fade_nx;
    end
  end

  assign bus.pwm_red   = pwm_ch[0];
  assign bus.pwm_green = pwm_ch[1];
  assign bus.pwm_blue  = pwm_ch[2];
  assign bus.fading    = fading_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: randomized and directed stimulus for led_fade_pwm, checked
// every cycle against a duty/period arithmetic model, plus literal expectations.
module tb_led_fade_pwm;
  import led_pkg::*;

  localparam int PB = 4;
  localparam int RD = 2;
  localparam int MX = 15;

`ifdef LED_FADE_GAMMA_EN
  localparam int EXP_P1 = 3;
  localparam int EXP_P2 = 12;
`else
  localparam int EXP_P1 = 7;
  localparam int EXP_P2 = 14;
`endif
  localparam int EXP_P3 = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] led_in = 3'b111;

  led_fade_pwm_if bus ();

  assign bus.led_red_in   = led_in[0];
  assign bus.led_green_in = led_in[1];
  assign bus.led_blue_in  = led_in[2];

  led_fade_pwm #(.PWM_BITS(PB), .RAMP_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_tgt[3];
  int m_duty[3];
  int m_shadow[3];
  int m_pwm[3];
  int m_ps;
  int m_cnt;
  int m_fading;
  bit m_tick;
  bit m_wrap;

  function automatic int eff(input int d);
`ifdef LED_FADE_GAMMA_EN
    if (d == MX) return MX;
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_tgt[c] = 0; m_duty[c] = 0; m_shadow[c] = 0; m_pwm[c] = 0;
      end
      m_ps = 0; m_cnt = 0; m_fading = 0;
    end else begin
      m_tick = (m_ps == RD - 1);
      m_wrap = (m_cnt == MX - 1);
      m_fading = 0;
      for (int c = 0; c < 3; c++) begin
        m_pwm[c] = (m_cnt < m_shadow[c]) ? 1 : 0;
        if (m_wrap) m_shadow[c] = eff(m_duty[c]);
        if (m_tick) begin
          if (m_tgt[c] != 0) m_duty[c] = (m_duty[c] < MX) ? m_duty[c] + 1 : MX;
          else               m_duty[c] = (m_duty[c] > 0)  ? m_duty[c] - 1 : 0;
        end
        m_tgt[c] = int'(led_in[c]);
        if (m_duty[c] > 0 && m_duty[c] < MX) m_fading = 1;
      end
      m_ps  = (m_ps + 1) % RD;
      m_cnt = (m_cnt + 1) % MX;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("pwm_red",   int'(bus.pwm_red),   m_pwm[0]);
    check("pwm_green", int'(bus.pwm_green), m_pwm[1]);
    check("pwm_blue",  int'(bus.pwm_blue),  m_pwm[2]);
    check("fading",    int'(bus.fading),    m_fading);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int p0, p1, p2, p3, fade_cnt, hi, t, rate;

  task automatic drain_all();
    led_in = 3'b000;
    t = 0;
    while ((m_duty[0] + m_duty[1] + m_duty[2]) != 0 && t < 200) begin
      @(negedge clk); t++;
    end
    check("drain_duty_zero", m_duty[0] + m_duty[1] + m_duty[2], 0);
    repeat (2 * MX + 2) @(negedge clk);
  endtask

  initial begin
    // Reset held with all inputs high.
    repeat (3) @(negedge clk);
    check("reset_pwm", int'({bus.pwm_blue, bus.pwm_green, bus.pwm_red}), 0);
    check("reset_fading", int'(bus.fading), 0);
    rst = 1'b0;

    // Fade-in from release: tick on every second edge, wraps at edges 15/30/45.
    p0 = 0; p1 = 0; p2 = 0; p3 = 0; fade_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("edge1_duty", int'(dut.u_ch_red.duty_q), 0);
      if (k == 1) check("edge1_fading", int'(bus.fading), 0);
      if (k == 2) check("edge2_duty", int'(dut.u_ch_red.duty_q), 1);
      if (k == 2) check("edge2_fading", int'(bus.fading), 1);
      if (k == 29) check("edge29_fading", int'(bus.fading), 1);
      if (k == 30) check("edge30_fading", int'(bus.fading), 0);
      if (k == 30) check("edge30_duty", int'(dut.u_ch_red.duty_q), MX);
      if (k == 30) check("model_edge30_duty", m_duty[0], MX);
      if (k <= 15) p0 += int'(bus.pwm_red);
      else if (k <= 30) p1 += int'(bus.pwm_red);
      else if (k <= 45) p2 += int'(bus.pwm_red);
      else p3 += int'(bus.pwm_red);
      fade_cnt += int'(bus.fading);
    end
    check("period0_high", p0, 0);
    check("period1_high", p1, EXP_P1);
    check("period2_high", p2, EXP_P2);
    check("period3_high", p3, EXP_P3);
    check("fading_edges", fade_cnt, 28);

    // Randomized levels with varying hold times, including sub-tick pulses.
    @(negedge clk);
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 2))
        0: rate = 1;
        1: rate = 15;
        default: rate = 60;
      endcase
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        for (int c = 0; c < 3; c++)
          if ($urandom_range(0, rate) == 0) led_in[c] = ~led_in[c];
      end
    end

    // Reversal on green at duty 8.
    drain_all();
    led_in[1] = 1'b1;
    t = 0;
    while (m_duty[1] != 8 && t < 100) begin
      @(negedge clk); t++;
    end
    check("rev_reach8", m_duty[1], 8);
    led_in[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rev_duty7", int'(dut.u_ch_green.duty_q), 7);
    check("rev_model7", m_duty[1], 7);
    check("rev_fading", int'(bus.fading), 1);
    repeat (12) @(posedge clk); #1;
    check("rev_duty1", int'(dut.u_ch_green.duty_q), 1);
    repeat (2) @(posedge clk); #1;
    check("rev_duty0", int'(dut.u_ch_green.duty_q), 0);
    check("rev_fading_off", int'(bus.fading), 0);
    repeat (2 * MX) @(posedge clk);
    hi = 0;
    for (int k = 0; k < MX; k++) begin
      @(posedge clk); #1;
      hi += int'(bus.pwm_green);
    end
    check("rev_green_dark", hi, 0);

    // Async reset while blue is mid-fade with its pin high.
    drain_all();
    led_in[2] = 1'b1;
    t = 0;
    while (!(m_duty[2] >= 6 && m_duty[2] < MX && m_pwm[2] == 1) && t < 200) begin
      @(negedge clk); t++;
    end
    check("pre_rst_pwm_blue", int'(bus.pwm_blue), 1);
    check("pre_rst_fading", int'(bus.fading), 1);
    #1 rst = 1'b1;
    #1;
    check("async_pwm_blue", int'(bus.pwm_blue), 0);
    check("async_fading", int'(bus.fading), 0);
    check("async_duty", int'(dut.u_ch_blue.duty_q), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_edge1_duty", int'(dut.u_ch_blue.duty_q), 0);
    @(posedge clk); #1;
    check("rel_edge2_duty", int'(dut.u_ch_blue.duty_q), 1);
    check("rel_edge2_fading", int'(bus.fading), 1);
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
